// File: rtl/hight_key_sched.sv
// hight_key_sched: HIGHT subkey / whitening-key source for the round datapath.
//   clk        : system clock, all state on the rising edge
//   reset      : synchronous, active-high reset
//   start      : pulse that latches MK/ed and begins key expansion
//   ed         : 1 = encrypt (forward group order), 0 = decrypt (reverse order)
//   MK         : 128-bit master key, MK0 = MK[7:0] ... MK15 = MK[127:120]
//   sk_next    : consumer pulse, advance to the next subkey group
//   SKx0..SKx3 : current subkey group SK[4g]..SK[4g+3]
//   WK0_4..WK3_7 : whitening keys for the current transformation
//   sk_valid   : SKx* hold a valid group
//   wk_final   : 0 = initial WK set shown, 1 = final WK set shown
//   busy       : expansion in progress
//   done       : all groups consumed, held until the next start or reset
module hight_key_sched (
    input  logic         clk,
    input  logic         reset,
    input  logic         start,
    input  logic         ed,
    input  logic [127:0] MK,
    input  logic         sk_next,
    output logic [7:0]   SKx0,
    output logic [7:0]   SKx1,
    output logic [7:0]   SKx2,
    output logic [7:0]   SKx3,
    output logic [7:0]   WK0_4,
    output logic [7:0]   WK1_5,
    output logic [7:0]   WK2_6,
    output logic [7:0]   WK3_7,
    output logic         sk_valid,
    output logic         wk_final,
    output logic         busy,
    output logic         done
);
    localparam int NGRP = 32;

    typedef enum logic [1:0] {IDLE, GEN, SERVE, DONE} state_t;

    state_t         state_q, state_d;
    logic [127:0]   mk_q, mk_d;
    logic           ed_q, ed_d;
    logic [4:0]     ptr_q, ptr_d;
    logic [6:0]     lfsr_q, lfsr_d;
    logic           sk_valid_q, sk_valid_d;
    logic [31:0]    rd_q, rd_d;
    logic [31:0]    mem [NGRP];
    logic [6:0]     d0, d1, d2, d3, d4;
    logic [27:0]    dl;
    logic [31:0]    grp;
    logic [3:0]     sk_idx;
    logic           wr_en, last, adv, fin_set;

    function automatic logic [6:0] step(input logic [6:0] d);
        return {d[3] ^ d[0], d[6:1]};
    endfunction

    assign d0 = lfsr_q;
    assign d1 = step(d0);
    assign d2 = step(d1);
    assign d3 = step(d2);
    assign d4 = step(d3);
    assign dl = {d3, d2, d1, d0};

    // During GEN the pointer is the group index g: round-key index k = 4g+j
    // gives i = g[4:2] and p = {g[1:0], j}; the byte index keeps p's half
    // (bit 3) and rotates the low three bits by -i.
    always_comb begin
        grp    = '0;
        sk_idx = '0;
        for (int j = 0; j < 4; j++) begin
            sk_idx = {ptr_q[1], 3'({ptr_q[0], 2'(j)} - ptr_q[4:2])};
            grp[8*j +: 8] = mk_q[{sk_idx, 3'b000} +: 8] + {1'b0, dl[7*j +: 7]};
        end
    end

    assign last = ed_q ? (ptr_q == 5'd31) : (ptr_q == 5'd0);
    assign adv  = sk_valid_q && sk_next;

    always_comb begin
        state_d    = state_q;
        mk_d       = mk_q;
        ed_d       = ed_q;
        ptr_d      = ptr_q;
        lfsr_d     = lfsr_q;
        sk_valid_d = sk_valid_q;
        rd_d       = rd_q;
        wr_en      = 1'b0;
        if (start) begin
            state_d    = GEN;
            mk_d       = MK;
            ed_d       = ed;
            ptr_d      = '0;
            lfsr_d     = 7'h5A;
            sk_valid_d = 1'b0;
            rd_d       = '0;
        end else begin
            case (state_q)
                GEN: begin
                    wr_en  = 1'b1;
                    lfsr_d = d4;
                    // Last group written this cycle; the first read is issued
                    // one cycle later so it sees the completed buffer.
                    if (ptr_q == 5'd31) begin
                        state_d = SERVE;
                        ptr_d   = ed_q ? 5'd0 : 5'd31;
                    end else begin
                        ptr_d = ptr_q + 5'd1;
                    end
                end
                SERVE: begin
                    if (adv && last) begin
                        state_d    = DONE;
                        sk_valid_d = 1'b0;
                    end else begin
                        sk_valid_d = 1'b1;
                        if (adv)
                            ptr_d = ed_q ? ptr_q + 5'd1 : ptr_q - 5'd1;
                    end
                    rd_d = mem[ptr_d];
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            mk_q       <= '0;
            ed_q       <= 1'b0;
            ptr_q      <= '0;
            lfsr_q     <= 7'h5A;
            sk_valid_q <= 1'b0;
            rd_q       <= '0;
        end else begin
            state_q    <= state_d;
            mk_q       <= mk_d;
            ed_q       <= ed_d;
            ptr_q      <= ptr_d;
            lfsr_q     <= lfsr_d;
            sk_valid_q <= sk_valid_d;
            rd_q       <= rd_d;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en)
            mem[ptr_q] <= grp;
    end

    assign {SKx3, SKx2, SKx1, SKx0} = rd_q;
    assign sk_valid = sk_valid_q;
    assign busy     = (state_q == GEN);
    assign done     = (state_q == DONE);
    assign wk_final = done;

    // Decrypt uses the encrypt final set (MK0..3) for its initial transformation.
    assign fin_set = wk_final ^ ~ed_q;
    assign {WK3_7, WK2_6, WK1_5, WK0_4} = (sk_valid_q || done) ?
                                          (fin_set ? mk_q[31:0] : mk_q[127:96]) : 32'h0;
endmodule

// File: doc/hight_key_sched.md
Name: hight_key_sched

Overview:
- Subkey and whitening-key producer for the HIGHT round datapath; it is the source end of the SKx0..SKx3 / WK0_4..WK3_7 interface.
- Expands the 128-bit master key into 128 round subkeys and stores them as 32 groups of 4 bytes.
- Serves one group per round on request, in forward order for encryption and reverse order for decryption.
- Presents whitening keys for the initial transformation, then switches to the final-transformation set.

Parameters:
NGRP, 32, number of 4-byte subkey groups (rounds); fixed by the algorithm, not to be overridden.

Ports:
clk  input  1  system clock, all state on rising edge
reset  input  1  synchronous, active-high reset
start  input  1  one-cycle pulse: latch MK and ed, begin expansion
ed  input  1  1 = encrypt order, 0 = decrypt order; sampled with start
MK  input  128  master key; MK0 = MK[7:0] ... MK15 = MK[127:120]
sk_next  input  1  consumer pulse: current group used, advance
SKx0,SKx1,SKx2,SKx3  output  8 each  current subkey group, SK[4g]..SK[4g+3]
WK0_4,WK1_5,WK2_6,WK3_7  output  8 each  whitening keys for the current transformation
sk_valid  output  1  SKx* hold a valid group
wk_final  output  1  0 = initial-transformation WK set shown, 1 = final set
busy  output  1  expansion in progress
done  output  1  all 32 groups consumed; held until next start or reset

Behaviour:
- Reset:
  - FSM enters IDLE.
  - All outputs are 0; group pointer is 0; LFSR holds 0x5A.
- Whitening keys:
  - WK0..3 = MK12..MK15; WK4..7 = MK0..MK3.
  - Encrypt: wk_final=0 shows WK0..3; wk_final=1 shows WK4..7.
  - Decrypt: the sets are swapped.
- Delta LFSR (7-bit):
  - d0 = 0x5A.
  - d(k+1) = {d(k)[3]^d(k)[0], d(k)[6:1]}.
  - Four combinational steps per cycle produce d(4g)..d(4g+3).
- Subkey rule for k = 16i+p:
  - p<8: SK_k = MK[(p-i) mod 8] + d_k.
  - p>=8: SK_k = MK[((p-8-i) mod 8)+8] + d_k.
  - Additions are mod 256, carry discarded.
- FSM IDLE:
  - start → GEN.
  - Latch MK and ed; load LFSR with 0x5A; set busy=1; clear done and sk_valid.
- FSM GEN:
  - Cycle g (0..31) writes group g into the 32x32-bit buffer.
  - After g=31: busy=0, go to SERVE.
  - Pointer loads 0 (ed=1) or 31 (ed=0); the buffer registered read is issued.
  - Exactly 33 clocks from the start edge to sk_valid=1.
  - SKx* and WK* become valid in the same cycle as sk_valid; wk_final=0.
- FSM SERVE:
  - sk_next advances the pointer (+1 encrypt, −1 decrypt); the new group appears on the next clock.
  - sk_valid stays 1 throughout, with zero bubble.
  - sk_next on the last group (31 encrypt, 0 decrypt) → DONE.
  - sk_next while not in SERVE is ignored.
- FSM DONE:
  - sk_valid=0, wk_final=1, done=1.
  - SKx* hold the last group; WK* show the final set.
- start during GEN, SERVE or DONE aborts the current key and restarts GEN with the new MK/ed; the buffer is overwritten.
- reset mid-operation returns to IDLE on the next edge; buffer contents are don't-care.
- start and sk_next in the same cycle: start wins.
- The pointer never wraps; no state exists beyond 32 groups.

Test Plan:
1. MK=0, ed=1, start → after 33 clk sk_valid=1, group0 = SKx0..3 = 5A,6D,36,1B; WK0_4..WK3_7 = 00,00,00,00; wk_final=0.
2. MK=0x00112233445566778899aabbccddeeff, ed=1 → group0 = 59,5B,13,E7; WK0_4..WK3_7 = 33,22,11,00; after 32 sk_next pulses: done=1, wk_final=1, WK0_4..WK3_7 = FF,EE,DD,CC.
3. Same MK, ed=0 → first group equals group31 from scenario 2; consecutive groups in reverse order; WK0_4..WK3_7 starts at FF,EE,DD,CC and ends at 33,22,11,00.
4. sk_next held high every cycle in SERVE → 32 distinct groups on 32 consecutive cycles, then done=1 the following cycle; compare against a software model of all 128 SKs.
5. start with MK=A during SERVE at group 10, then MK=B → busy=1 next cycle, sk_valid=0, and after 33 clk group0 of B is shown with no residue of A.
6. reset asserted during GEN cycle 15 → next cycle all outputs are 0 and the FSM is in IDLE; sk_next pulses are ignored until a new start.
